// File: rtl/program_loader_if.sv
// Byte stream from the UART receiver into the loader: plain valid/ready handshake.
interface program_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/program_loader.sv
// Boot loader: parses LEN_L/LEN_H/data/CHK frames into instruction memory, then releases the core.
// Write pulse one cycle after a word's 4th byte; rx_ready held high while loading, so no stalls.
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  program_loader_if.slave   rx,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CAPACITY = 2**ADDR_W;

  typedef enum logic [2:0] {
    stLen0,
    stLen1,
    stData,
    stChk,
    stRun,
    stError
  } state_t;

  state_t          state;
  logic [7:0]      lenLo;
  logic [ADDR_W:0] wordsTotal;
  logic [1:0]      byteCnt;
  logic [23:0]     asmReg;
  logic [7:0]      xorAcc;
  logic            xfer;
  logic [15:0]     lenWord;

  always_comb begin
    xfer    = rx.rx_valid && rx.rx_ready;
    lenWord = {rx.rx_data, lenLo};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= stLen0;
      rx.rx_ready  <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      lenLo        <= '0;
      wordsTotal   <= '0;
      byteCnt      <= '0;
      asmReg       <= '0;
      xorAcc       <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        stLen0: begin
          if (xfer) begin
            lenLo <= rx.rx_data;
            state <= stLen1;
          end
        end

        stLen1: begin
          if (xfer) begin
            if (lenWord == 16'd0) begin
              state <= stChk;
            end else if (32'(lenWord) > CAPACITY) begin
              state       <= stError;
              rx.rx_ready <= 1'b0;
              load_error  <= 1'b1;
            end else begin
              wordsTotal <= lenWord[ADDR_W:0];
              byteCnt    <= '0;
              state      <= stData;
            end
          end
        end

        // Bytes shift in from the top so the first byte lands in bits [7:0].
        stData: begin
          if (xfer) begin
            xorAcc  <= xorAcc ^ rx.rx_data;
            byteCnt <= byteCnt + 2'd1;
            if (byteCnt == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= {rx.rx_data, asmReg};
              words_loaded <= words_loaded + 1'b1;
              if (words_loaded + 1'b1 == wordsTotal) begin
                state <= stChk;
              end
            end else begin
              asmReg <= {rx.rx_data, asmReg[23:8]};
            end
          end
        end

        stChk: begin
          if (xfer) begin
            rx.rx_ready <= 1'b0;
            if (rx.rx_data == xorAcc) begin
              state     <= stRun;
              cpu_reset <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state      <= stError;
              load_error <= 1'b1;
            end
          end
        end

        stRun, stError: begin
          if (reload) begin
            state        <= stLen0;
            rx.rx_ready  <= 1'b1;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            xorAcc       <= '0;
            byteCnt      <= '0;
          end
        end

        default: begin
          state <= stLen0;
        end
      endcase
    end
  end

endmodule
